// File: rtl/demod_ber.sv
// demod_ber: PRBS7 (x^7+x^6+1) bit-error-rate checker with SEARCH/VERIFY/LOCKED acquisition.
// Optional loss-of-lock window detector enabled by `define DEMOD_BER_LOSS_DETECT_EN.
module demod_ber #(
  parameter int unsigned LOCK_LEN = 16,
  parameter int unsigned WIN_LEN  = 128,
  parameter int unsigned LOSS_THR = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_signal,
  input  logic             rst_n,
  input  logic             signal,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int unsigned MATCH_W = $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [6:0]         r_lfsr;
  logic [6:0]         w_lfsr_nxt;
  logic [2:0]         r_fill;
  logic [2:0]         w_fill_nxt;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err_flag;
  logic               r_locked;
  logic               w_pred;
  logic               w_err;
  logic               w_in_lock;
  logic               w_loss;

  // Window and threshold values only shape logic in the loss-detect build; degenerate values elaborate nothing here.
  if (WIN_LEN == 0 || LOSS_THR == 0 || LOCK_LEN == 0) begin : g_bad_cfg
  end

  assign w_pred    = r_lfsr[6] ^ r_lfsr[5];
  assign w_err     = signal ^ w_pred;
  assign w_in_lock = (r_state == LOCKED);

`ifdef DEMOD_BER_LOSS_DETECT_EN
  localparam int unsigned WIN_W = $clog2(WIN_LEN + 1);
  localparam int unsigned THR_W = $clog2(LOSS_THR + 1);

  logic [WIN_W-1:0] r_win_cnt;
  logic [THR_W-1:0] r_win_err;
  logic [THR_W-1:0] w_win_err_sum;

  // Window error count stays below LOSS_THR, so the sum never overflows THR_W.
  assign w_win_err_sum = r_win_err + THR_W'(w_err);
  assign w_loss        = w_in_lock && (w_win_err_sum >= THR_W'(LOSS_THR));

  // Window bookkeeping: the last bit of a window is judged before the window restarts.
  always_ff @(posedge clk_signal) begin
    if (!rst_n || clear || w_loss || !w_in_lock) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
      r_win_err <= w_win_err_sum;
    end
  end
`else
  assign w_loss = 1'b0;
`endif

  // Acquisition FSM next-state: fill from the line in SEARCH, free-run the generator afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    case (r_state)
      SEARCH: begin
        w_lfsr_nxt = {r_lfsr[5:0], signal};
        if (r_fill == 3'd6) begin
          w_fill_nxt  = '0;
          w_match_nxt = '0;
          if (w_lfsr_nxt != 7'd0) begin
            w_state_nxt = VERIFY;
          end
        end else begin
          w_fill_nxt = r_fill + 3'd1;
        end
      end
      VERIFY: begin
        w_lfsr_nxt = {r_lfsr[5:0], w_pred};
        if (w_err) begin
          w_state_nxt = SEARCH;
          w_fill_nxt  = '0;
          w_match_nxt = '0;
        end else if (r_match == MATCH_W'(LOCK_LEN - 1)) begin
          w_state_nxt = LOCKED;
          w_match_nxt = '0;
        end else begin
          w_match_nxt = r_match + MATCH_W'(1);
        end
      end
      LOCKED: begin
        w_lfsr_nxt = {r_lfsr[5:0], w_pred};
        if (w_loss) begin
          w_state_nxt = SEARCH;
          w_fill_nxt  = '0;
          w_match_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_fill_nxt  = '0;
        w_match_nxt = '0;
      end
    endcase
  end

  // FSM and generator state registers.
  always_ff @(posedge clk_signal) begin
    if (!rst_n) begin
      r_state  <= SEARCH;
      r_lfsr   <= '0;
      r_fill   <= '0;
      r_match  <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_fill   <= w_fill_nxt;
      r_match  <= w_match_nxt;
      r_locked <= (w_state_nxt == LOCKED);
    end
  end

  // Saturating BER counters; clear wins over a same-cycle increment but not over the error pulse.
  always_ff @(posedge clk_signal) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else begin
      r_err_flag <= w_in_lock && w_err;
      if (clear) begin
        r_bit_cnt <= '0;
        r_err_cnt <= '0;
      end else if (w_in_lock) begin
        if (r_bit_cnt != {CNT_W{1'b1}}) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
        if (w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign locked   = r_locked;
  assign state    = r_state;
  assign bit_cnt  = r_bit_cnt;
  assign err_cnt  = r_err_cnt;
  assign err_flag = r_err_flag;

endmodule

// File: tb/tb_demod_ber.sv
// tb_demod_ber: scoreboard bench driving a CNT_W=16 and a CNT_W=4 demod_ber from one stream,
// compared each cycle against a recurrence-based behavioural model.
module tb_demod_ber;

  localparam int     LOCK_LEN = 16;
  localparam int     WIN_LEN  = 128;
  localparam int     LOSS_THR = 16;
  localparam longint MAX16    = 65535;
  localparam longint MAX4     = 15;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig   = 1'b0;
  logic        clr   = 1'b0;
  logic        l16, l4, f16, f4;
  logic [1:0]  s16, s4;
  logic [15:0] b16, e16;
  logic [3:0]  b4, e4;

  demod_ber #(.LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(16)) u_dut16 (
    .clk_signal(clk), .rst_n(rst_n), .signal(sig), .clear(clr),
    .locked(l16), .state(s16), .bit_cnt(b16), .err_cnt(e16), .err_flag(f16)
  );

  demod_ber #(.LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(4)) u_dut4 (
    .clk_signal(clk), .rst_n(rst_n), .signal(sig), .clear(clr),
    .locked(l4), .state(s4), .bit_cnt(b4), .err_cnt(e4), .err_flag(f4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     st;
    bit     flag;
    longint bits;
    longint errs;
  } exp_t;

  exp_t   sb_q[$];
  int     checks   = 0;
  int     failures = 0;

  // Model state: phase, fill/match counts, the last seven sequence bits, raw (unsaturated) counts.
  int     m_st, m_fill, m_match, m_win_cnt, m_win_err;
  bit     m_hist[$];
  longint m_bits, m_errs;
  bit     src[$];

  task automatic cmp(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  // Behavioural reference: PRBS7 as the recurrence s[n] = s[n-7] ^ s[n-6].
  task automatic model_step(input bit s, input bit c, input bit rn);
    bit   p, e, flag, any1;
    exp_t x;
    flag = 1'b0;
    if (!rn) begin
      m_st = 0; m_fill = 0; m_match = 0; m_win_cnt = 0; m_win_err = 0;
      m_bits = 0; m_errs = 0;
      m_hist.delete();
      repeat (7) m_hist.push_back(1'b0);
    end else begin
      p = m_hist[0] ^ m_hist[1];
      e = (s != p);
      case (m_st)
        0: begin
          m_hist.push_back(s);
          void'(m_hist.pop_front());
          m_fill++;
          if (m_fill == 7) begin
            m_fill = 0;
            any1 = 1'b0;
            foreach (m_hist[i]) any1 |= m_hist[i];
            if (any1) begin
              m_st = 1;
              m_match = 0;
            end
          end
        end
        1: begin
          m_hist.push_back(p);
          void'(m_hist.pop_front());
          if (e) begin
            m_st = 0; m_fill = 0; m_match = 0;
          end else begin
            m_match++;
            if (m_match == LOCK_LEN) begin
              m_st = 2;
              m_match = 0;
            end
          end
        end
        default: begin
          m_hist.push_back(p);
          void'(m_hist.pop_front());
          m_bits++;
          if (e) begin
            m_errs++;
            flag = 1'b1;
          end
`ifdef DEMOD_BER_LOSS_DETECT_EN
          m_win_cnt++;
          m_win_err += int'(e);
          if (m_win_err >= LOSS_THR) begin
            m_st = 0; m_fill = 0; m_win_cnt = 0; m_win_err = 0;
          end else if (m_win_cnt == WIN_LEN) begin
            m_win_cnt = 0; m_win_err = 0;
          end
`endif
        end
      endcase
      if (c) begin
        m_bits = 0; m_errs = 0; m_win_cnt = 0; m_win_err = 0;
      end
    end
    x.st = m_st; x.flag = flag; x.bits = m_bits; x.errs = m_errs;
    sb_q.push_back(x);
  endtask

  task automatic drive(input bit s, input bit c, input bit rn);
    @(negedge clk);
    sig = s; clr = c; rst_n = rn;
    model_step(s, c, rn);
  endtask

  task automatic src_seed();
    logic [6:0] seed;
    seed = 7'($urandom_range(1, 127));
    src.delete();
    for (int i = 6; i >= 0; i--) src.push_back(seed[i]);
  endtask

  function automatic bit src_next();
    bit b;
    b = src[0] ^ src[1];
    src.push_back(b);
    void'(src.pop_front());
    return b;
  endfunction

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per clocked cycle, compared just after the edge.
  always begin : mon
    exp_t x;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      cmp("state16",  longint'(s16), longint'(x.st));
      cmp("locked16", longint'(l16), longint'(x.st == 2));
      cmp("flag16",   longint'(f16), longint'(x.flag));
      cmp("bits16",   longint'(b16), sat(x.bits, MAX16));
      cmp("errs16",   longint'(e16), sat(x.errs, MAX16));
      cmp("state4",   longint'(s4),  longint'(x.st));
      cmp("flag4",    longint'(f4),  longint'(x.flag));
      cmp("bits4",    longint'(b4),  sat(x.bits, MAX4));
      cmp("errs4",    longint'(e4),  sat(x.errs, MAX4));
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // Reset with junk on the inputs.
    repeat (3) drive(1'($urandom), 1'($urandom), 1'b0);
    post_edge();
    cmp("reset_state", longint'(s16), 0);
    cmp("reset_bits",  longint'(b16), 0);

    // Clean stream: VERIFY after bit 7, lock after bit 23, no errors.
    src_seed();
    for (int i = 1; i <= 1000; i++) begin
      drive(src_next(), 1'b0, 1'b1);
      if (i == 7)  begin post_edge(); cmp("verify_at_7",  longint'(s16), 1); end
      if (i == 22) begin post_edge(); cmp("unlocked_22",  longint'(l16), 0); end
      if (i == 23) begin post_edge(); cmp("locked_23",    longint'(l16), 1); end
    end
    post_edge();
    cmp("clean_errs", longint'(e16), 0);

    // Three isolated inverted bits within 500.
    drive(src_next(), 1'b1, 1'b1);
    for (int i = 1; i <= 500; i++) begin
      drive(src_next() ^ ((i == 100) || (i == 250) || (i == 400)), 1'b0, 1'b1);
    end
    post_edge();
    cmp("three_errs", longint'(e16), 3);

    // Constant zero never acquires.
    drive(1'b0, 1'b0, 1'b0);
    repeat (100) drive(1'b0, 1'b0, 1'b1);
    post_edge();
    cmp("zero_search", longint'(s16), 0);

    // Error after 10 VERIFY matches, then fresh 7+16 bits.
    drive(1'b0, 1'b0, 1'b0);
    src_seed();
    repeat (17) drive(src_next(), 1'b0, 1'b1);
    drive(~src_next(), 1'b0, 1'b1);
    post_edge();
    cmp("verify_err_search", longint'(s16), 0);
    repeat (22) drive(src_next(), 1'b0, 1'b1);
    post_edge();
    cmp("relock_not_yet", longint'(l16), 0);
    drive(src_next(), 1'b0, 1'b1);
    post_edge();
    cmp("relock_done", longint'(l16), 1);

    // Random line after lock, with sporadic clears that may coincide with errors.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), ($urandom_range(0, 15) == 0), 1'b1);
    end

    // Saturation at CNT_W=4, then clear.
    drive(1'b0, 1'b0, 1'b0);
    src_seed();
    repeat (43) drive(src_next(), 1'b0, 1'b1);
    drive(src_next(), 1'b1, 1'b1);
    repeat (20) drive(~src_next(), 1'b0, 1'b1);
    post_edge();
    cmp("sat_bits4", longint'(b4), 15);
    cmp("sat_errs4", longint'(e4), 15);
    drive(src_next(), 1'b1, 1'b1);
    post_edge();
    cmp("clear_bits4", longint'(b4), 0);
    cmp("clear_errs4", longint'(e4), 0);
`ifndef DEMOD_BER_LOSS_DETECT_EN
    cmp("clear_keeps_lock", longint'(l4), 1);
`endif

    // Reset mid-lock: full 7+LOCK_LEN reacquisition.
    src_seed();
    repeat (40) drive(src_next(), 1'b0, 1'b1);
    drive(src_next(), 1'b0, 1'b0);
    repeat (22) drive(src_next(), 1'b0, 1'b1);
    post_edge();
    cmp("rst_relock_not_yet", longint'(l16), 0);
    drive(src_next(), 1'b0, 1'b1);
    post_edge();
    cmp("rst_relock_done", longint'(l16), 1);
    repeat (30) drive(src_next(), 1'b0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    n = 0;
    while ((sb_q.size() > 0) && (n < 10)) begin
      @(posedge clk);
      n++;
    end
    #3;
    cmp("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
